// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen bus slice: bus status codes and initiator FSM states.
// Optional feature macro used by this slice: RGGEN_BUS_INITIATOR_TIMEOUT_EN.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACCESS   = 2'b01,
    RESPONSE = 2'b10
  } rggen_bus_initiator_state;

  localparam int RGGEN_TIMER_WIDTH = 16;

endpackage

// File: rtl/rggen_bus_if.sv
// Simple register bus: one valid/ready access with address, write data and strobe.
// Master drives the request side, slave returns ready, status and read data.
interface rggen_bus_if
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);

  logic                     valid;
  logic [ADDRESS_WIDTH-1:0] address;
  logic                     write;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH/8-1:0]   strobe;
  logic                     ready;
  rggen_status              status;
  logic [BUS_WIDTH-1:0]     read_data;

  modport master (
    output valid, address, write, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, address, write, write_data, strobe,
    output ready, status, read_data
  );

endinterface

// File: rtl/rggen_bus_initiator_timer.sv
// Wait-cycle counter for the bus initiator; flags the last allowed cycle.
// Instantiated only when RGGEN_BUS_INITIATOR_TIMEOUT_EN is defined.
module rggen_bus_initiator_timer
  import rggen_rtl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_terminal
);

  localparam int W = RGGEN_TIMER_WIDTH;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign o_terminal = (count_q == W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_count && !o_terminal) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rggen_bus_initiator.sv
// Command/response front end issuing one register bus access at a time.
// Define RGGEN_BUS_INITIATOR_TIMEOUT_EN to bound the wait for bus ready.
module rggen_bus_initiator
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic                     i_cmd_write,
  input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output rggen_status              o_rsp_status,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
  rggen_bus_if.master              bus_if
);

  localparam int SW = BUS_WIDTH / 8;

  rggen_bus_initiator_state state_q, state_d;

  logic                     cmd_ready_q, cmd_ready_d;
  logic                     valid_q, valid_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic                     write_q, write_d;
  logic [BUS_WIDTH-1:0]     wdata_q, wdata_d;
  logic [SW-1:0]            strobe_q, strobe_d;
  logic                     rsp_valid_q, rsp_valid_d;
  rggen_status              rsp_status_q, rsp_status_d;
  logic [BUS_WIDTH-1:0]     rdata_q, rdata_d;

  logic accept;
  logic timeout;
  logic done;

  assign accept = i_cmd_valid && cmd_ready_q;

`ifdef RGGEN_BUS_INITIATOR_TIMEOUT_EN
  logic terminal;

  rggen_bus_initiator_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (accept),
    .i_count    (valid_q && !bus_if.ready),
    .o_terminal (terminal)
  );

  // A ready arriving on the terminal cycle still completes normally.
  assign timeout = valid_q && !bus_if.ready && terminal;
`else
  logic [15:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 16'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  assign done = valid_q && (bus_if.ready || timeout);

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    valid_d      = valid_q;
    address_d    = address_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    strobe_d     = strobe_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_status_d = rsp_status_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = ACCESS;
          cmd_ready_d = 1'b0;
          valid_d     = 1'b1;
          address_d   = i_cmd_address;
          write_d     = i_cmd_write;
          wdata_d     = i_cmd_write_data;
          strobe_d    = i_cmd_strobe;
        end
      end
      ACCESS: begin
        if (done) begin
          state_d      = RESPONSE;
          valid_d      = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = timeout ? RGGEN_SLAVE_ERROR : bus_if.status;
          rdata_d      = (write_q || timeout) ? '0 : bus_if.read_data;
        end
      end
      RESPONSE: begin
        if (i_rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        valid_d     = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b1;
      valid_q      <= 1'b0;
      address_q    <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      strobe_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= RGGEN_OKAY;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      valid_q      <= valid_d;
      address_q    <= address_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      strobe_q     <= strobe_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rdata_q      <= rdata_d;
    end
  end

  assign o_cmd_ready       = cmd_ready_q;
  assign o_rsp_valid       = rsp_valid_q;
  assign o_rsp_status      = rsp_status_q;
  assign o_rsp_read_data   = rdata_q;
  assign bus_if.valid      = valid_q;
  assign bus_if.address    = address_q;
  assign bus_if.write      = write_q;
  assign bus_if.write_data = wdata_q;
  assign bus_if.strobe     = strobe_q;

endmodule

// File: doc/rggen_bus_initiator.md
RGGEN_BUS_INITIATOR -- requirements
Module: rggen_bus_initiator

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16, bus address width.
REQ-002 SHALL have parameter BUS_WIDTH, default 32, data width; multiple of 8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles an access waits for ready (timeout build only); legal range 1..65535.
REQ-004 SHALL have one clock and a synchronous, active-high reset: i_clk in 1 clock; i_rst in 1 reset.
REQ-005 SHALL have: i_cmd_valid in 1 command request.
REQ-006 SHALL have: o_cmd_ready out 1 command accepted when high with i_cmd_valid.
REQ-007 SHALL have: i_cmd_address in ADDRESS_WIDTH; i_cmd_write in 1; i_cmd_write_data in BUS_WIDTH; i_cmd_strobe in BUS_WIDTH/8.
REQ-008 SHALL have: o_rsp_valid out 1; i_rsp_ready in 1; o_rsp_status out rggen_status; o_rsp_read_data out BUS_WIDTH.
REQ-009 SHALL have: bus_if rggen_bus_if.master, driving valid/address/write/write_data/strobe, sampling ready/status/read_data.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, RESPONSE; one access outstanding.
REQ-011 IDLE: o_cmd_ready=1; on i_cmd_valid&o_cmd_ready SHALL register all cmd fields and enter ACCESS next cycle.
REQ-012 ACCESS: bus_if.valid=1 with address/write/write_data/strobe driven from registers, stable until completion.
REQ-013 ACCESS completes on the first cycle bus_if.ready=1; status captured; read_data captured for reads, zero for writes; RESPONSE entered next cycle.
REQ-014 bus_if.valid SHALL be 0 in the cycle after completion; no ACCESS re-entry without a new command.
REQ-015 RESPONSE: o_rsp_valid=1, data/status held stable until i_rsp_ready=1, then IDLE next cycle.
REQ-016 Latency: command accepted cycle N -> bus valid N+1; ready at N+1 -> o_rsp_valid N+2.
REQ-017 o_cmd_ready SHALL be 0 in ACCESS and RESPONSE; commands offered then are ignored.
REQ-018 bus_if.ready seen while bus_if.valid=0 SHALL be ignored.

Reset
REQ-019 i_rst SHALL force IDLE next edge; o_cmd_ready=1, bus_if.valid=0, o_rsp_valid=0, o_rsp_status=RGGEN_OKAY, o_rsp_read_data=0, address/write_data/strobe/write=0, timeout counter=0.
REQ-020 Reset mid-ACCESS or mid-RESPONSE SHALL abandon the transaction without a response.

Configuration
REQ-021 Macro RGGEN_BUS_INITIATOR_TIMEOUT_EN defined: counter clears on ACCESS entry, increments each ACCESS cycle without ready; after TIMEOUT_CYCLES such cycles SHALL complete with RGGEN_SLAVE_ERROR, read_data 0, drop valid.
REQ-022 Ready in the same cycle as terminal count SHALL win: real status/data returned.
REQ-023 Macro undefined: no counter logic; ACCESS waits indefinitely; TIMEOUT_CYCLES unused.

Structure
REQ-024 rggen_status and its values SHALL come from rggen_rtl_pkg; FSM state enum SHALL be added there as rggen_bus_initiator_state.
REQ-025 Counter SHALL be sub-module rggen_bus_initiator_timer, instantiated only under the macro.

Verification
REQ-026 Write 0x0010, data 0xDEADBEEF, strobe 0xF, slave ready on first cycle -> bus valid N+1 with those fields, rsp OKAY/read_data 0 at N+2.
REQ-027 Read 0x0020, slave 3 wait cycles then ready, read_data 0x12345678 -> fields stable 4 cycles, rsp OKAY/0x12345678.
REQ-028 Response held 5 cycles with i_rsp_ready=0, i_cmd_valid=1 -> o_cmd_ready=0, rsp fields stable, new command accepted only after IDLE.
REQ-029 Timeout build, TIMEOUT_CYCLES=4, slave never ready -> valid drops after 4 cycles, rsp SLAVE_ERROR, read_data 0; ready at cycle 4 -> real status.
REQ-030 i_rst in 2nd ACCESS cycle -> next edge valid=0, o_rsp_valid=0, o_cmd_ready=1; next command proceeds normally.
REQ-031 Slave returns RGGEN_DECODE_ERROR on read -> o_rsp_status DECODE_ERROR, status passed through unchanged.
